rv32i_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the RV32I core. It generates PCs, issues single-outstanding requests to instruction memory, and buffers returned words with their PCs in a small FIFO. It presents them to the decode stage, which feeds the instruction splitter, over a valid/ready handshake. It also handles back-pressure from decode and control-flow redirects, including flush and discard of in-flight responses.

---
 rtl/rv32i_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_rv32i_fetch_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_ctrl.sv
// Instruction-fetch sequencer: single-outstanding imem requests, a small
// {pc, instruction} FIFO toward decode, and redirect/flush handling.
module rv32i_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instruction,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    output logic        busy
);

    // state | meaning
    // IDLE  | one-cycle gap: after reset release, or after a withdrawn request
    // REQ   | imem_req asserted at fetch_pc, waiting for gnt
    // WAIT  | granted, waiting for the single rvalid
    // HOLD  | FIFO full, no request until decode pops
    // DRAIN | stale response in flight, dropped when it returns
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam int          AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [31:0]     pc_mem_q    [FIFO_DEPTH];
    logic [31:0]     instr_mem_q [FIFO_DEPTH];

    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            flush;
    logic [31:0]     redirect_target;
    logic [AW:0]     occ_after_push;

    assign fifo_empty      = (count_q == '0);
    assign dec_valid       = !fifo_empty && !redirect_valid;
    assign dec_instruction = instr_mem_q[rd_ptr_q];
    assign dec_pc          = pc_mem_q[rd_ptr_q];
    assign pop             = dec_valid && dec_ready;
    assign imem_addr       = fetch_pc_q;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign occ_after_push  = count_q + (AW+1)'(1) - (AW+1)'(pop);
    assign busy            = imem_req || (state_q == S_WAIT) || (state_q == S_DRAIN) || !fifo_empty;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        imem_req   = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_target;
                end
            end
            S_REQ: begin
                // Credit: nothing is outstanding here, so only FIFO room matters.
                imem_req = (count_q < DEPTH) || pop;
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_target;
                    state_d    = (imem_req && imem_gnt) ? S_DRAIN : S_IDLE;
                end else if (imem_req && imem_gnt) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_target;
                    state_d    = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = (occ_after_push < DEPTH) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_target;
                    state_d    = S_REQ;
                end else if (pop) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_target;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                // fetch_pc already advanced at grant, so the response PC is one word back.
                if (push) begin
                    pc_mem_q[wr_ptr_q]    <= fetch_pc_q - 32'd4;
                    instr_mem_q[wr_ptr_q] <= imem_rdata;
                    wr_ptr_q              <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Scoreboard bench for rv32i_fetch_ctrl: expected grant addresses and decode
// pairs are queued by the stimulus and popped by an independent monitor.
module tb_rv32i_fetch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instruction;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        busy;

    logic        w_rst_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_dec_valid;
    logic [31:0] w_dec_instr;
    logic [31:0] w_dec_pc;
    logic        w_busy;

    rv32i_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_instruction(dec_instruction), .dec_pc(dec_pc),
        .dec_ready(dec_ready), .busy(busy)
    );

    rv32i_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .dec_valid(w_dec_valid), .dec_instruction(w_dec_instr), .dec_pc(w_dec_pc),
        .dec_ready(1'b1), .busy(w_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_gnt = 0;
    int cyc = 0;
    int first_gnt_cyc = -1;
    int first_dv_cyc = -1;
    int rsp_delay = 1;

    logic [31:0] addr_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] wq[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a == 32'h0) ? 32'h003100B3 : {a[23:0], 8'h13};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, instr_of(pc)});
    endtask

    task automatic wait_grants(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (n_gnt >= target) return;
        end
        timeout("wait_grants");
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) return;
        end
        timeout("wait_drain");
    endtask

    task automatic reset_enter();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory model with programmable grant-to-rvalid delay.
    logic        g_s = 1'b0;
    logic [31:0] a_s = '0;
    always @(negedge clk) begin
        g_s <= rst_n && imem_req && imem_gnt;
        a_s <= imem_addr;
    end

    initial begin
        bit          pend;
        int          cnt;
        logic [31:0] pend_addr;
        pend = 0; cnt = 0; pend_addr = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (g_s) begin
                    pend = 1; cnt = rsp_delay; pend_addr = a_s;
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = instr_of(pend_addr);
                        pend = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    always @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_rvalid <= 1'b0;
            w_rdata  <= '0;
        end else begin
            w_rvalid <= w_req;
            w_rdata  <= w_addr;
        end
    end

    // Monitor: compares every grant and every decode handshake against the queues.
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_gnt) begin
            n_gnt++;
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
            if (addr_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_grant: addr %h with empty queue", imem_addr);
            end else begin
                check("grant_addr", imem_addr, addr_q.pop_front());
            end
        end
        if (rst_n && dec_valid && first_dv_cyc < 0) first_dv_cyc = cyc;
        if (rst_n && dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_dec: pc %h instr %h with empty queue", dec_pc, dec_instruction);
            end else begin
                check("dec_pc_instr", {dec_pc, dec_instruction}, exp_q.pop_front());
            end
        end
        if (w_rst_n && w_req && wq.size() > 0) begin
            check("wrap_addr", w_addr, wq.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0; w_rst_n = 1'b0;
        imem_gnt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_dec_instr", dec_instruction, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_busy", busy, 1'b0);

        // Streaming fetch with gnt tied high and single-cycle response.
        @(posedge clk); #1;
        addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        imem_gnt = 1'b1; dec_ready = 1'b1; rsp_delay = 1;
        base = n_gnt;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_req", imem_req, 1'b0);
        @(negedge clk);
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        wait_grants(base + 3, 40);
        imem_gnt = 1'b0;
        wait_drain(40);
        check("first_dv_latency", 64'(first_dv_cyc - first_gnt_cyc), 64'd2);
        check("p1_addr_q_empty", addr_q.size(), 0);

        // Back-pressure: exactly two grants, then HOLD with head stable.
        reset_enter();
        dec_ready = 1'b0; imem_gnt = 1'b1; rsp_delay = 1;
        addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        base = n_gnt;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("hold_grants", n_gnt - base, 2);
        check("hold_no_req", imem_req, 1'b0);
        check("hold_dec_valid", dec_valid, 1'b1);
        check("hold_head_pc", dec_pc, 32'h0);
        check("hold_head_instr", dec_instruction, 32'h003100B3);
        check("hold_busy", busy, 1'b1);
        @(posedge clk); #1;
        dec_ready = 1'b1;
        wait_grants(base + 3, 40);
        imem_gnt = 1'b0;
        wait_drain(40);
        check("p2_addr_q_empty", addr_q.size(), 0);

        // Redirect while WAIT; stale response returns three cycles later.
        rsp_delay = 4;
        addr_q.push_back(32'hC); addr_q.push_back(32'h1000);
        push_exp(32'h1000);
        base = n_gnt;
        imem_gnt = 1'b1;
        wait_grants(base + 1, 20);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
        @(posedge clk); #1;
        redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);
        check("drain_no_req", imem_req, 1'b0);
        check("drain_busy", busy, 1'b1);
        check("drain_dec_valid", dec_valid, 1'b0);
        wait_grants(base + 2, 30);
        imem_gnt = 1'b0;
        wait_drain(40);
        check("p3_addr_q_empty", addr_q.size(), 0);

        // Redirect during an ungranted request with one buffered entry.
        dec_ready = 1'b0; rsp_delay = 1;
        addr_q.push_back(32'h1004);
        base = n_gnt;
        imem_gnt = 1'b1;
        wait_grants(base + 1, 20);
        imem_gnt = 1'b0;
        @(posedge clk); #1;
        check("p4_pre_dec_valid", dec_valid, 1'b1);
        check("p4_pre_dec_pc", dec_pc, 32'h1004);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        @(negedge clk);
        check("p4_redir_req", imem_req, 1'b1);
        check("p4_redir_dec_forced", dec_valid, 1'b0);
        @(posedge clk); #1;
        redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);
        check("p4_gap_req", imem_req, 1'b0);
        check("p4_flushed", dec_valid, 1'b0);
        check("p4_gap_busy", busy, 1'b0);
        @(negedge clk);
        check("p4_new_req", imem_req, 1'b1);
        check("p4_new_addr", imem_addr, 32'h2000);
        @(posedge clk); #1;
        addr_q.push_back(32'h2000);
        push_exp(32'h2000);
        dec_ready = 1'b1;
        imem_gnt = 1'b1;
        wait_grants(base + 2, 20);
        imem_gnt = 1'b0;
        wait_drain(40);

        // PC wrap-around from a non-zero reset PC.
        wq.push_back(32'hFFFF_FFF8); wq.push_back(32'hFFFF_FFFC); wq.push_back(32'h0);
        w_rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (wq.size() == 0) break;
        end
        check("wrap_all_seen", wq.size(), 0);

        // Async reset while one entry is buffered and a response is in flight.
        dec_ready = 1'b0; rsp_delay = 3;
        addr_q.push_back(32'h2004); addr_q.push_back(32'h2008);
        base = n_gnt;
        imem_gnt = 1'b1;
        wait_grants(base + 2, 30);
        imem_gnt = 1'b0;
        #2;
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_dec_valid", dec_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", imem_req, 1'b0);
        check("async_rst_addr", imem_addr, 32'h0);
        check("async_rst_dec_valid", dec_valid, 1'b0);
        check("async_rst_dec_instr", dec_instruction, 32'h0);
        check("async_rst_dec_pc", dec_pc, 32'h0);
        check("async_rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        addr_q.push_back(32'h0);
        push_exp(32'h0);
        dec_ready = 1'b1; rsp_delay = 1; imem_gnt = 1'b1;
        rst_n = 1'b1;
        wait_grants(base + 3, 20);
        imem_gnt = 1'b0;
        wait_drain(40);

        repeat (4) @(posedge clk);
        check("final_addr_q_empty", addr_q.size(), 0);
        check("final_exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
